// File: rtl/stdio_arbiter.sv
// Round-robin arbiter sharing one stdio consumer between N producers.
// Each grant covers at most BURST words; winning words land in a one-entry output stage tagged with their source.
module stdio_arbiter #(
    parameter int N     = 2,
    parameter int BURST = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         stdin_val,
    input  logic [N-1:0][15:0]   stdin_data,
    output logic [N-1:0]         stdin_rdy,
    output logic                 stdout_val,
    output logic [15:0]          stdout_data,
    input  logic                 stdout_rdy,
    output logic [$clog2(N)-1:0] src_o
);
    localparam int W  = $clog2(N);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  owner_reg, owner_next;
    logic [W-1:0]  ptr_reg, ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
    logic          val_reg, val_next;
    logic [15:0]   data_reg, data_next;
    logic [W-1:0]  src_reg, src_next;

    logic          can_load;
    logic          owner_val;
    logic          xfer;
    logic [N-1:0]  rot_req;
    logic [W-1:0]  rot_idx [N];
    logic [W-1:0]  sel;

    // Explicit mod N keeps indices in range for non-power-of-2 N.
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input int unsigned b);
        int unsigned s;
        s = (32'(a) + b) % 32'(N);
        return W'(s);
    endfunction

    // rot_req[0] is the producer at ptr, rot_req[1] the next one, and so on.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot_idx[gi] = wrap_add(ptr_reg, gi);
            assign rot_req[gi] = stdin_val[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        sel = ptr_reg;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_req[k]) sel = rot_idx[k];
        end
    end

    assign can_load  = ~val_reg | stdout_rdy;
    assign owner_val = stdin_val[owner_reg];
    assign xfer      = (state_reg == GRANT) && can_load && owner_val;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            owner_reg <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            val_reg   <= 1'b0;
            data_reg  <= 16'h0000;
            src_reg   <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            val_reg   <= val_next;
            data_reg  <= data_next;
            src_reg   <= src_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        val_next   = val_reg;
        data_next  = data_reg;
        src_next   = src_reg;
        cnt_inc    = cnt_reg + 1'b1;

        // A consumed word empties the stage unless a new one replaces it this cycle.
        if (stdout_rdy) val_next = 1'b0;
        if (xfer) begin
            val_next  = 1'b1;
            data_next = stdin_data[owner_reg];
            src_next  = owner_reg;
            cnt_next  = cnt_inc;
        end

        case (state_reg)
            IDLE: begin
                if (|stdin_val) begin
                    owner_next = sel;
                    cnt_next   = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // A stalled output (can_load low) pins the grant in place.
                if ((xfer && (cnt_inc == CW'(BURST))) || (can_load && !owner_val)) begin
                    state_next = IDLE;
                    ptr_next   = wrap_add(owner_reg, 1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stdin_rdy = '0;
        if (state_reg == GRANT) stdin_rdy[owner_reg] = can_load;
    end

    assign stdout_val  = val_reg;
    assign stdout_data = data_reg;
    assign src_o       = src_reg;

endmodule

// File: tb/tb_stdio_arbiter.sv
// Self-checking bench for stdio_arbiter: an N=2/BURST=4 instance for most scenarios
// and an N=3/BURST=1 instance for wrap-around; expectations come from a burst-level model.
module tb_stdio_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       in_val;
    logic [1:0][15:0] in_data;
    logic [1:0]       in_rdy;
    logic             out_val;
    logic [15:0]      out_data;
    logic             out_rdy;
    logic [0:0]       src;

    logic [2:0]       c_val;
    logic [2:0][15:0] c_data;
    logic [2:0]       c_rdy;
    logic             c_out_val;
    logic [15:0]      c_out_data;
    logic             c_out_rdy;
    logic [1:0]       c_src;

    stdio_arbiter #(.N(2), .BURST(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .stdin_val(in_val), .stdin_data(in_data), .stdin_rdy(in_rdy),
        .stdout_val(out_val), .stdout_data(out_data), .stdout_rdy(out_rdy),
        .src_o(src)
    );

    stdio_arbiter #(.N(3), .BURST(1)) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .stdin_val(c_val), .stdin_data(c_data), .stdin_rdy(c_rdy),
        .stdout_val(c_out_val), .stdout_data(c_out_data), .stdout_rdy(c_out_rdy),
        .src_o(c_src)
    );

    localparam int BURST = 4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        nrst = 1'b0;
    logic        ordy = 1'b1;
    logic [1:0]  en = '0;
    logic [2:0]  en3 = '0;
    logic [15:0] pq0[$];
    logic [15:0] pq1[$];
    logic [15:0] log_data[$];
    int          log_src[$];
    int          log_cyc[$];
    int          c3_src[$];
    logic [15:0] c3_data[$];
    logic [15:0] exp_d[$];
    int          exp_s[$];

    // One clock cycle: drive inputs after the falling edge, then record handshakes.
    task automatic step();
        logic [15:0] tmp;
        @(negedge clk);
        cyc++;
        rst_n      = nrst;
        out_rdy    = ordy;
        c_out_rdy  = 1'b1;
        in_val[0]  = en[0] && (pq0.size() > 0);
        in_data[0] = (pq0.size() > 0) ? pq0[0] : 16'h0000;
        in_val[1]  = en[1] && (pq1.size() > 0);
        in_data[1] = (pq1.size() > 0) ? pq1[0] : 16'h0000;
        for (int i = 0; i < 3; i++) begin
            c_val[i]  = en3[i];
            c_data[i] = {4'(i), 12'(cyc)};
        end
        #1;
        if (in_val[0] && in_rdy[0]) tmp = pq0.pop_front();
        if (in_val[1] && in_rdy[1]) tmp = pq1.pop_front();
        if (out_val === 1'b1 && out_rdy) begin
            log_data.push_back(out_data);
            log_src.push_back(int'(src));
            log_cyc.push_back(cyc);
            $display("out   cyc=%0d src=%0d data=%h", cyc, src, out_data);
        end
        if (c_out_val === 1'b1) begin
            c3_src.push_back(int'(c_src));
            c3_data.push_back(c_out_data);
            $display("out3  cyc=%0d src=%0d data=%h", cyc, c_src, c_out_data);
        end
    endtask

    task automatic do_reset();
        en = '0; en3 = '0; ordy = 1'b1;
        pq0.delete(); pq1.delete();
        nrst = 1'b0;
        step();
        step();
        nrst = 1'b1;
        log_data.delete(); log_src.delete(); log_cyc.delete();
        c3_src.delete(); c3_data.delete();
        cyc = -1;
    endtask

    // Burst-level model: from ptr, the first producer with words gets up to BURST of them.
    task automatic build_expected(input logic [15:0] e0_in[$], input logic [15:0] e1_in[$]);
        logic [15:0] e0[$];
        logic [15:0] e1[$];
        int ptr, own;
        e0 = e0_in; e1 = e1_in;
        exp_d.delete(); exp_s.delete();
        ptr = 0;
        while (e0.size() + e1.size() > 0) begin
            if (ptr == 0) own = (e0.size() > 0) ? 0 : 1;
            else          own = (e1.size() > 0) ? 1 : 0;
            for (int k = 0; k < BURST; k++) begin
                if (own == 0 && e0.size() > 0) begin exp_d.push_back(e0.pop_front()); exp_s.push_back(0); end
                if (own == 1 && e1.size() > 0) begin exp_d.push_back(e1.pop_front()); exp_s.push_back(1); end
            end
            ptr = (own + 1) % 2;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_val, out_data, src, in_rdy} !== 20'h0) begin
            errors++;
            $display("FAIL reset_out: val=%b data=%h src=%b rdy=%b, want all zero", out_val, out_data, src, in_rdy);
        end
        checks++;
        if ({c_out_val, c_out_data, c_src, c_rdy} !== 22'h0) begin
            errors++;
            $display("FAIL reset_out3: val=%b data=%h src=%b rdy=%b, want all zero", c_out_val, c_out_data, c_src, c_rdy);
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 1; k <= 6; k++) pq0.push_back(16'(k));
        en = 2'b01;
        for (int c = 0; c < 12; c++) begin
            step();
            if (c == 1 || c == 5) begin
                checks++;
                if (in_rdy !== ((c == 1) ? 2'b01 : 2'b00)) begin
                    errors++;
                    $display("FAIL single_rdy c=%0d: got %b want %b", c, in_rdy, (c == 1) ? 2'b01 : 2'b00);
                end
            end
        end
        checks++;
        if (log_data.size() != 6) begin
            errors++;
            $display("FAIL single_count: got %0d want 6", log_data.size());
        end
        for (int k = 0; k < 6 && k < log_data.size(); k++) begin
            checks++;
            if (log_data[k] !== 16'(k + 1) || log_src[k] != 0 || log_cyc[k] != 2 + k + k / BURST) begin
                errors++;
                $display("FAIL single_word%0d: got data=%h src=%0d cyc=%0d want data=%h src=0 cyc=%0d",
                         k, log_data[k], log_src[k], log_cyc[k], 16'(k + 1), 2 + k + k / BURST);
            end
        end
    endtask

    task automatic test_contention(input bit rnd);
        int n0, n1;
        do_reset();
        n0 = rnd ? int'($urandom_range(1, 10)) : 12;
        n1 = rnd ? int'($urandom_range(1, 10)) : 12;
        for (int k = 0; k < n0; k++) pq0.push_back(rnd ? 16'($urandom) : 16'hA000 + 16'(k));
        for (int k = 0; k < n1; k++) pq1.push_back(rnd ? 16'($urandom) : 16'hB000 + 16'(k));
        build_expected(pq0, pq1);
        en = 2'b11;
        for (int c = 0; c < 400; c++) begin
            ordy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            if (pq0.size() == 0 && pq1.size() == 0 && log_data.size() >= exp_d.size()) break;
        end
        ordy = 1'b1;
        checks++;
        if (log_data.size() != exp_d.size()) begin
            errors++;
            $display("FAIL contention_count rnd=%0d: got %0d want %0d", rnd, log_data.size(), exp_d.size());
        end
        for (int k = 0; k < exp_d.size() && k < log_data.size(); k++) begin
            checks++;
            if (log_data[k] !== exp_d[k] || log_src[k] != exp_s[k]) begin
                errors++;
                $display("FAIL contention_word%0d rnd=%0d: got data=%h src=%0d want data=%h src=%0d",
                         k, rnd, log_data[k], log_src[k], exp_d[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] e0[$];
        logic [15:0] e1[$];
        logic [15:0] held;
        int s, idx;
        do_reset();
        for (int k = 0; k < 8; k++) pq0.push_back(16'($urandom));
        for (int k = 0; k < 4; k++) pq1.push_back(16'($urandom));
        e0 = pq0; e1 = pq1;
        held = e0[1];
        en = 2'b11;
        for (int c = 0; c < 150; c++) begin
            ordy  = !(c >= 3 && c <= 7);
            en[0] = !(c >= 5 && c <= 7);
            step();
            if (c >= 3 && c <= 7) begin
                checks++;
                if ({out_val, out_data, src, in_rdy} !== {1'b1, held, 1'b0, 2'b00}) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d: got val=%b data=%h src=%b rdy=%b want val=1 data=%h src=0 rdy=00",
                             c, out_val, out_data, src, in_rdy, held);
                end
            end
            if (c == 8) begin
                checks++;
                if (in_rdy !== 2'b01) begin
                    errors++;
                    $display("FAIL stall_resume: rdy got %b want 01", in_rdy);
                end
            end
            if (c > 8 && pq0.size() == 0 && pq1.size() == 0 && log_data.size() >= 12) break;
        end
        checks++;
        if (log_data.size() != 12) begin
            errors++;
            $display("FAIL stall_count: got %0d want 12", log_data.size());
        end
        for (int k = 0; k < 12 && k < log_data.size(); k++) begin
            s   = (k / 4) % 2;
            idx = (k < 4) ? k : k - 4;
            checks++;
            if (log_src[k] != s || log_data[k] !== ((s == 0) ? e0[idx] : e1[idx])) begin
                errors++;
                $display("FAIL stall_word%0d: got data=%h src=%0d want data=%h src=%0d",
                         k, log_data[k], log_src[k], (s == 0) ? e0[idx] : e1[idx], s);
            end
        end
    endtask

    task automatic test_early_release();
        logic [15:0] e0[$];
        logic [15:0] e1[$];
        do_reset();
        for (int k = 0; k < 2; k++) pq1.push_back(16'($urandom));
        for (int k = 0; k < 3; k++) pq0.push_back(16'($urandom));
        e0 = pq0; e1 = pq1;
        en = 2'b10;
        for (int c = 0; c < 80; c++) begin
            if (c == 2) en[0] = 1'b1;
            if (c == 4) begin
                for (int k = 0; k < 2; k++) begin
                    pq1.push_back(16'($urandom));
                    e1.push_back(pq1[pq1.size() - 1]);
                end
            end
            step();
            if (c == 4 || c == 5) begin
                checks++;
                if (in_rdy !== ((c == 4) ? 2'b00 : 2'b01)) begin
                    errors++;
                    $display("FAIL early_rdy c=%0d: got %b want %b", c, in_rdy, (c == 4) ? 2'b00 : 2'b01);
                end
            end
            if (c > 5 && pq0.size() == 0 && pq1.size() == 0 && log_data.size() >= 7) break;
        end
        exp_d = {e1[0], e1[1], e0[0], e0[1], e0[2], e1[2], e1[3]};
        exp_s = {1, 1, 0, 0, 0, 1, 1};
        checks++;
        if (log_data.size() != 7) begin
            errors++;
            $display("FAIL early_count: got %0d want 7", log_data.size());
        end
        for (int k = 0; k < 7 && k < log_data.size(); k++) begin
            checks++;
            if (log_data[k] !== exp_d[k] || log_src[k] != exp_s[k]) begin
                errors++;
                $display("FAIL early_word%0d: got data=%h src=%0d want data=%h src=%0d",
                         k, log_data[k], log_src[k], exp_d[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        en3 = 3'b111;
        for (int c = 0; c < 20; c++) step();
        checks++;
        if (c3_src.size() < 6) begin
            errors++;
            $display("FAIL wrap_count: got %0d want at least 6", c3_src.size());
        end
        for (int k = 0; k < c3_src.size(); k++) begin
            checks++;
            if (c3_src[k] != k % 3 || int'(c3_data[k][15:12]) != k % 3) begin
                errors++;
                $display("FAIL wrap_grant%0d: got src=%0d tag=%0d want %0d", k, c3_src[k], c3_data[k][15:12], k % 3);
            end
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        for (int k = 0; k < 6; k++) pq0.push_back(16'($urandom));
        for (int k = 0; k < 4; k++) pq1.push_back(16'($urandom));
        en = 2'b11;
        for (int c = 0; c < 6; c++) begin
            ordy = (c != 3);
            nrst = (c != 3);
            step();
            if (c == 3) begin
                checks++;
                if (out_val !== 1'b1) begin
                    errors++;
                    $display("FAIL midburst_held: val got %b want 1", out_val);
                end
            end
            if (c == 4) begin
                checks++;
                if ({out_val, out_data, src, in_rdy} !== 20'h0) begin
                    errors++;
                    $display("FAIL midburst_reset: val=%b data=%h src=%b rdy=%b, want all zero", out_val, out_data, src, in_rdy);
                end
            end
            if (c == 5) begin
                checks++;
                if (in_rdy !== 2'b01) begin
                    errors++;
                    $display("FAIL midburst_regrant: rdy got %b want 01", in_rdy);
                end
            end
        end
        nrst = 1'b1;
    endtask

    initial begin
        in_val = '0; in_data = '0; out_rdy = 1'b1;
        c_val = '0; c_data = '0; c_out_rdy = 1'b1;
        test_reset();
        test_single();
        test_contention(1'b0);
        test_stall();
        test_early_release();
        test_wrap();
        test_reset_midburst();
        for (int r = 0; r < 4; r++) test_contention(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stdio_arbiter.md
# stdio_arbiter

Round-robin arbiter that shares one `stdio` consumer (typically a `fifo` feeding the console/stdout path) between `N` `stdio` producers, such as the CPU core, the front-panel loader and the debug port. It grants one producer at a time for a bounded burst of words and registers the winning word into a one-entry output stage. `src_o` tags each output word with its origin. The block sits between the producers and the shared FIFO.

## Interface
- `N`, default 2: number of producers; N ≥ 2.
- `BURST`, default 4: maximum words accepted per grant; BURST ≥ 1.
- `clk_i`  in  1: single clock; all state updates on rising edge.
- `rst_ni`  in  1: reset, synchronous, active-low.
- `stdin[0:N-1]`  stdio.in  16-bit data: producer ports (`val`, `data` in; `rdy` out).
- `stdout`  stdio.out  16-bit data: shared consumer port (`val`, `data` out; `rdy` in).
- `src_o`  out  $clog2(N): index of the producer whose word is in `stdout.data`.

## Operation
- State: `IDLE`, `GRANT`. Registers: `owner` ($clog2(N)), `ptr` ($clog2(N)), `cnt` ($clog2(BURST+1)), output stage (`stdout.val`, `stdout.data`, `src_o`).
- `can_load` = `~stdout.val | stdout.rdy`.
- **IDLE**
  - All `stdin[i].rdy` = 0.
  - If any `stdin[i].val` = 1, select the first requester scanning `ptr, ptr+1, … ptr+N-1` mod N.
  - Set `owner` = that index, `cnt` = 0, and go to `GRANT`.
  - If no producer is requesting, stay in `IDLE`.
- **GRANT**
  - `stdin[owner].rdy` = `can_load`; every other `rdy` = 0.
  - Transfer when `stdin[owner].val & stdin[owner].rdy`:
    - Load `stdout.data` = `stdin[owner].data`, `src_o` = `owner`, `stdout.val` = 1.
    - `cnt` increments.
  - Release to `IDLE` and set `ptr` = (`owner`+1) mod N when either:
    - a transfer makes `cnt` reach BURST, or
    - `can_load` = 1 and `stdin[owner].val` = 0 (the owner has gone idle).
  - When `can_load` = 0, stay in `GRANT` regardless of the owner's `val`. No release while the output is stalled.
- **Output stage**
  - Word consumed when `stdout.val & stdout.rdy`.
  - If no load happens in the same cycle, `stdout.val` clears.
  - Consume and load in the same cycle gives back-to-back words with no bubble.
  - `stdout.data` and `src_o` stay stable while `stdout.val` = 1 and `stdout.rdy` = 0.
- **Modulo arithmetic**
  - `ptr`/`owner` wrap from N-1 to 0 with explicit mod N.
  - For non-power-of-2 N, indices ≥ N never occur.
- **Fairness**: a continuously requesting producer waits at most (N-1) grants of ≤ BURST words each.
- **Reset** (`rst_ni` = 0 at an edge):
  - State `IDLE`, `ptr` = 0, `owner` = 0, `cnt` = 0.
  - `stdout.val` = 0, `stdout.data` = 16'h0000, `src_o` = 0.
  - All `stdin[i].rdy` = 0 from that cycle onward.
  - A word held in the output stage is discarded. A burst in progress is abandoned with no partial state kept.

## Timing
- Arbitration costs one cycle:
  - Request first seen in `IDLE` at cycle t.
  - `rdy` asserted to the winner in cycle t+1.
  - Word accepted at the end of t+1.
  - `stdout.val` = 1 in t+2.
- Within a grant, throughput is 1 word/cycle while `stdout.rdy` = 1.
- Gap between grants is exactly 1 cycle (the `IDLE` cycle), including when the same producer is re-granted.
- Producer-to-`stdout` latency is 1 cycle from acceptance.
- `rdy` outputs are combinational from state and `stdout.rdy`. There is no combinational path from any `stdin[i].val` to any `rdy`.

## Test plan
- **Single producer.** N=2, BURST=4, `stdout.rdy` = 1. Producer 0 streams 16'h0001..16'h0006.
  - Output order is 1,2,3,4 with `src_o` = 0.
  - One-cycle gap, then 5,6.
  - `ptr` = 1 after each release.
- **Contention, round-robin.** Both producers hold `val` = 1 continuously; producer 0 sends 16'hA000+k, producer 1 sends 16'hB000+k.
  - Output is A000..A003, then B000..B003, then A004..A007.
  - `src_o` alternates 0/1 per burst; no starvation.
- **Output stall.** Stall `stdout.rdy` = 0 for 5 cycles during a grant.
  - `stdout.data` and `src_o` hold constant.
  - Owner `rdy` = 0 during the stall, and the grant is not released even if the owner drops `val`.
  - Exactly one extra word is accepted when `rdy` returns.
- **Early release.** Producer 1 sends 2 words, then drops `val`.
  - Release occurs after 2 words.
  - Pending producer 0 is granted on the next `IDLE` cycle, and `ptr` = 0 after producer 1 releases.
- **Wrap-around and non-power-of-2.** N=3, BURST=1, all producers requesting.
  - Grant order is 0,1,2,0,1,…
  - `src_o` never equals 3.
- **Reset mid-burst.** Assert `rst_ni` = 0 while a word is held and `cnt` = 2.
  - Next cycle: `stdout.val` = 0, `stdout.data` = 0, `src_o` = 0, all `rdy` = 0.
  - After release, producer 0 is granted first.
